alu_issue: RTL and testbench



---
 rtl/alu_issue_if.sv | 31 +++
 rtl/alu_issue.sv | 195 +++++++++++++++++++
 tb/tb_alu_issue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Issue-to-execute bus: ALU operands, op code and the instruction context
// that travels alongside them. The issue stage is the master.
interface alu_issue_if #(
  parameter int XLEN       = 32,
  parameter int ALU_OP_MSB = 3
) ();
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_a;
  logic [XLEN-1:0]     out_b;
  logic [ALU_OP_MSB:0] out_op;
  logic                out_is_cond;
  logic [XLEN-1:0]     out_imm;
  logic [XLEN-1:0]     out_pc;
  logic [4:0]          out_rd;
  logic                out_we;
  logic                out_illegal;
  logic [7:0]          out_seq;

  modport master (
    output out_valid, out_a, out_b, out_op, out_is_cond, out_imm,
           out_pc, out_rd, out_we, out_illegal, out_seq,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_a, out_b, out_op, out_is_cond, out_imm,
           out_pc, out_rd, out_we, out_illegal, out_seq,
    output out_ready
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes ALU-class instructions, reads operands
// and holds one issued entry for execute behind a valid/ready handshake.
module alu_issue (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  input  logic              flush,
  alu_issue_if.master       issue
);
  localparam int XLEN = 32;
  localparam int XMSB = XLEN - 1;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,  ALU_OP_SUB  = 4'd1,  ALU_OP_SLL  = 4'd2,
    ALU_OP_SLT  = 4'd3,  ALU_OP_SLTU = 4'd4,  ALU_OP_XOR  = 4'd5,
    ALU_OP_SRL  = 4'd6,  ALU_OP_SRA  = 4'd7,  ALU_OP_OR   = 4'd8,
    ALU_OP_AND  = 4'd9,  ALU_OP_EQ   = 4'd10, ALU_OP_NE   = 4'd11,
    ALU_OP_LT   = 4'd12, ALU_OP_GE   = 4'd13, ALU_OP_LTU  = 4'd14,
    ALU_OP_GEU  = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [XMSB:0] i_imm, u_imm, b_imm, shamt;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign funct7   = in_instr[31:25];

  assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
  assign u_imm = {in_instr[31:12], 12'b0};
  assign b_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign shamt = {27'b0, in_instr[24:20]};

  logic [XMSB:0] dec_a, dec_b, dec_imm;
  alu_op_e       dec_op;
  logic          dec_cond, dec_writes, dec_legal;

  always_comb begin
    // NOTE: every decode output gets a default first so no path infers a latch.
    dec_a      = '0;
    dec_b      = '0;
    dec_imm    = '0;
    dec_op     = ALU_OP_ADD;
    dec_cond   = 1'b0;
    dec_writes = 1'b0;
    dec_legal  = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        dec_a      = rs1_data;
        dec_b      = rs2_data;
        dec_writes = 1'b1;
        if (funct7 == 7'b0) begin
          unique case (funct3)
            3'b000: dec_op = ALU_OP_ADD;
            3'b001: dec_op = ALU_OP_SLL;
            3'b010: dec_op = ALU_OP_SLT;
            3'b011: dec_op = ALU_OP_SLTU;
            3'b100: dec_op = ALU_OP_XOR;
            3'b101: dec_op = ALU_OP_SRL;
            3'b110: dec_op = ALU_OP_OR;
            default: dec_op = ALU_OP_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = ALU_OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = ALU_OP_SRA;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_a      = rs1_data;
        dec_b      = i_imm;
        dec_imm    = i_imm;
        dec_writes = 1'b1;
        unique case (funct3)
          3'b000: dec_op = ALU_OP_ADD;
          3'b010: dec_op = ALU_OP_SLT;
          3'b011: dec_op = ALU_OP_SLTU;
          3'b100: dec_op = ALU_OP_XOR;
          3'b110: dec_op = ALU_OP_OR;
          3'b111: dec_op = ALU_OP_AND;
          3'b001: begin
            dec_op    = ALU_OP_SLL;
            dec_b     = shamt;
            dec_legal = (funct7 == 7'b0);
          end
          default: begin
            dec_op    = (funct7 == F7_ALT) ? ALU_OP_SRA : ALU_OP_SRL;
            dec_b     = shamt;
            dec_legal = (funct7 == 7'b0) || (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec_b      = u_imm;
        dec_imm    = u_imm;
        dec_writes = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a      = in_pc;
        dec_b      = u_imm;
        dec_imm    = u_imm;
        dec_writes = 1'b1;
      end
      OPC_BRANCH: begin
        dec_a    = rs1_data;
        dec_b    = rs2_data;
        dec_imm  = b_imm;
        dec_cond = 1'b1;
        unique case (funct3)
          3'b000: dec_op = ALU_OP_EQ;
          3'b001: dec_op = ALU_OP_NE;
          3'b100: dec_op = ALU_OP_LT;
          3'b101: dec_op = ALU_OP_GE;
          3'b110: dec_op = ALU_OP_LTU;
          3'b111: dec_op = ALU_OP_GEU;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase

    // Illegal instructions still issue, but with a neutral payload.
    if (!dec_legal) begin
      dec_a      = '0;
      dec_b      = '0;
      dec_imm    = '0;
      dec_op     = ALU_OP_ADD;
      dec_cond   = 1'b0;
      dec_writes = 1'b0;
    end
  end

  logic       accept;
  logic [7:0] seq_next;

  assign in_ready = !issue.out_valid || issue.out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      issue.out_valid   <= 1'b0;
      issue.out_a       <= '0;
      issue.out_b       <= '0;
      issue.out_op      <= ALU_OP_ADD;
      issue.out_is_cond <= 1'b0;
      issue.out_imm     <= '0;
      issue.out_pc      <= '0;
      issue.out_rd      <= '0;
      issue.out_we      <= 1'b0;
      issue.out_illegal <= 1'b0;
      issue.out_seq     <= '0;
      seq_next          <= '0;
    end else if (flush) begin
      issue.out_valid <= 1'b0;
    end else if (accept) begin
      issue.out_valid   <= 1'b1;
      issue.out_a       <= dec_a;
      issue.out_b       <= dec_b;
      issue.out_op      <= dec_op;
      issue.out_is_cond <= dec_cond;
      issue.out_imm     <= dec_imm;
      issue.out_pc      <= in_pc;
      issue.out_rd      <= rd;
      issue.out_we      <= dec_writes && (rd != 5'd0);
      issue.out_illegal <= !dec_legal;
      issue.out_seq     <= seq_next;
      seq_next          <= seq_next + 8'd1;
    end else if (issue.out_ready) begin
      issue.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue: decode cases, backpressure, flush,
// sequence-tag wrap and asynchronous reset.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr;

  int vectors = 0;
  int miscompares = 0;
  int exp_seq = 0;

  localparam logic [31:0] OP_ADD = 0, OP_SRA = 7, OP_EQ = 10;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SRAI  = 32'h40335293;
  localparam logic [31:0] I_SLLIX = 32'h40331293;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BX    = 32'h0020A463;
  localparam logic [31:0] I_LUI   = 32'h123453B7;
  localparam logic [31:0] I_AUIPC = 32'h00001497;

  alu_issue_if #(.XLEN(32), .ALU_OP_MSB(3)) issue_bus ();

  alu_issue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .issue    (issue_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    in_instr = instr;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_instr = '0; in_pc = 32'h40;
    rs1_data = '0; rs2_data = '0; issue_bus.out_ready = 1'b1;
    #2;
    check("rst_valid", {31'b0, issue_bus.out_valid}, 0);
    check("rst_seq", {24'b0, issue_bus.out_seq}, 0);
    check("rst_ready", {31'b0, in_ready}, 1);
    check("rst_op", {28'b0, issue_bus.out_op}, OP_ADD);
    check("rst_a", issue_bus.out_a, 0);
    tick(); tick();
    rst_n = 1'b1;

    // ADD x3,x1,x2
    drive(I_ADD, 32'd5, 32'd7);
    #1;
    check("add_rs1_addr", {27'b0, rs1_addr}, 1);
    check("add_rs2_addr", {27'b0, rs2_addr}, 2);
    tick();
    check("add_valid", {31'b0, issue_bus.out_valid}, 1);
    check("add_a", issue_bus.out_a, 5);
    check("add_b", issue_bus.out_b, 7);
    check("add_op", {28'b0, issue_bus.out_op}, OP_ADD);
    check("add_rd", {27'b0, issue_bus.out_rd}, 3);
    check("add_we", {31'b0, issue_bus.out_we}, 1);
    check("add_cond", {31'b0, issue_bus.out_is_cond}, 0);
    check("add_seq", {24'b0, issue_bus.out_seq}, 0);
    check("add_pc", issue_bus.out_pc, 32'h40);

    // SRAI x5,x6,3
    drive(I_SRAI, 32'h80000000, 32'h0);
    tick();
    check("srai_op", {28'b0, issue_bus.out_op}, OP_SRA);
    check("srai_a", issue_bus.out_a, 32'h80000000);
    check("srai_b", issue_bus.out_b, 3);
    check("srai_rd", {27'b0, issue_bus.out_rd}, 5);
    check("srai_seq", {24'b0, issue_bus.out_seq}, 1);

    // SLLI with funct7=0100000 is illegal
    drive(I_SLLIX, 32'h1234, 32'h0);
    tick();
    check("slli_bad_ill", {31'b0, issue_bus.out_illegal}, 1);
    check("slli_bad_we", {31'b0, issue_bus.out_we}, 0);
    check("slli_bad_a", issue_bus.out_a, 0);
    check("slli_bad_valid", {31'b0, issue_bus.out_valid}, 1);

    // BEQ x1,x2,+8
    drive(I_BEQ, 32'h11, 32'h22);
    tick();
    check("beq_cond", {31'b0, issue_bus.out_is_cond}, 1);
    check("beq_op", {28'b0, issue_bus.out_op}, OP_EQ);
    check("beq_imm", issue_bus.out_imm, 8);
    check("beq_we", {31'b0, issue_bus.out_we}, 0);
    check("beq_b", issue_bus.out_b, 32'h22);
    check("beq_ill", {31'b0, issue_bus.out_illegal}, 0);

    // Branch funct3=010 is illegal
    drive(I_BX, 32'h11, 32'h22);
    tick();
    check("bx_ill", {31'b0, issue_bus.out_illegal}, 1);
    check("bx_cond", {31'b0, issue_bus.out_is_cond}, 0);
    check("bx_imm", issue_bus.out_imm, 0);

    // LUI x7,0x12345
    drive(I_LUI, 32'hFFFF, 32'hFFFF);
    tick();
    check("lui_a", issue_bus.out_a, 0);
    check("lui_b", issue_bus.out_b, 32'h12345000);
    check("lui_rd", {27'b0, issue_bus.out_rd}, 7);
    check("lui_seq", {24'b0, issue_bus.out_seq}, 5);

    // Backpressure: AUIPC x9,1 offered while execute stalls
    issue_bus.out_ready = 1'b0;
    drive(I_AUIPC, 32'hDEAD, 32'hBEEF);
    in_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 0);
      tick();
      check("bp_b_hold", issue_bus.out_b, 32'h12345000);
      check("bp_seq_hold", {24'b0, issue_bus.out_seq}, 5);
      check("bp_valid", {31'b0, issue_bus.out_valid}, 1);
    end
    issue_bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 1);
    tick();
    check("auipc_a", issue_bus.out_a, 32'h100);
    check("auipc_b", issue_bus.out_b, 32'h1000);
    check("auipc_rd", {27'b0, issue_bus.out_rd}, 9);
    check("auipc_seq", {24'b0, issue_bus.out_seq}, 6);

    // Flush concurrent with an accept
    drive(I_ADD, 32'd1, 32'd2);
    flush = 1'b1;
    #1;
    check("flush_ready_ungated", {31'b0, in_ready}, 1);
    tick();
    check("flush_acc_valid", {31'b0, issue_bus.out_valid}, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_idle_valid", {31'b0, issue_bus.out_valid}, 0);
    drive(I_ADD, 32'd1, 32'd2);
    tick();
    check("post_flush_seq", {24'b0, issue_bus.out_seq}, 7);
    check("post_flush_a", issue_bus.out_a, 1);

    // Consume with no new input, payload holds
    in_valid = 1'b0;
    tick();
    check("drain_valid", {31'b0, issue_bus.out_valid}, 0);
    check("drain_seq_hold", {24'b0, issue_bus.out_seq}, 7);

    // Flush with no input drops a stalled entry
    drive(I_ADD, 32'd9, 32'd9);
    tick();
    check("pre_flush2_valid", {31'b0, issue_bus.out_valid}, 1);
    issue_bus.out_ready = 1'b0;
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    check("flush_held_valid", {31'b0, issue_bus.out_valid}, 0);
    flush = 1'b0;
    issue_bus.out_ready = 1'b1;

    // 256 back-to-back issues: tag wraps 255 -> 0
    exp_seq = 9;
    drive(I_ADD, 32'd3, 32'd4);
    for (int k = 0; k < 256; k++) begin
      tick();
      check("wrap_seq", {24'b0, issue_bus.out_seq}, exp_seq & 255);
      exp_seq++;
    end
    check("wrap_valid", {31'b0, issue_bus.out_valid}, 1);

    // Asynchronous reset mid-stream, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, issue_bus.out_valid}, 0);
    check("arst_seq", {24'b0, issue_bus.out_seq}, 0);
    check("arst_ready", {31'b0, in_ready}, 1);
    check("arst_a", issue_bus.out_a, 0);
    tick();
    check("arst_ignore_input", {31'b0, issue_bus.out_valid}, 0);
    rst_n = 1'b1;
    drive(I_LUI, 32'd0, 32'd0);
    tick();
    check("post_rst_seq", {24'b0, issue_bus.out_seq}, 0);
    check("post_rst_valid", {31'b0, issue_bus.out_valid}, 1);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
